wave_sdram_arbiter: RTL
=======================

WAVE_SDRAM_ARBITER -- requirements
Module: wave_sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25: SDRAM byte address width.
REQ-002 SHALL have parameter TIMEOUT, default 64: watchdog limit in clk cycles; used only under REQ-029.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dl_active  in  1  ROM download in progress; blocks new channel grants.
REQ-006 dl_wr  in  1  single-cycle download write strobe.
REQ-007 dl_addr  in  ADDR_W  download write address.
REQ-008 dl_data  in  8  download write byte.
REQ-009 ch_req  in  4  per-channel wave read request level.
REQ-010 ch_addr  in  80  packed 4x20-bit channel word addresses; channel n uses bits [20n+19:20n].
REQ-011 ch_ack  out  4  one-hot, single-cycle read completion pulse.
REQ-012 ch_data  out  16  read data; valid in the ch_ack cycle, held until the next ack.
REQ-013 sd_addr  out  ADDR_W  SDRAM address.
REQ-014 sd_we  out  1  single-cycle SDRAM write command.
REQ-015 sd_rd  out  1  single-cycle SDRAM read command.
REQ-016 sd_din  out  8  SDRAM write byte.
REQ-017 sd_dout  in  16  SDRAM read data.
REQ-018 sd_ready  in  1  single-cycle SDRAM completion pulse.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 dl_ovf  out  1  sticky flag: a download write was dropped.
REQ-021 err  out  1  sticky flag: SDRAM timeout occurred (REQ-029).

Function
- REQ-022 FSM states SHALL be IDLE, WR, RD and ACK, with exactly one SDRAM transaction outstanding at a time.
- REQ-023 A dl_wr pulse SHALL be captured into a one-entry hold register (address and data) regardless of FSM state.
  - If dl_wr arrives while the register is already full and not being consumed in the same cycle, the new write SHALL be dropped and dl_ovf set.
- REQ-024 IDLE: a full hold register has top priority.
  - Next cycle: sd_we=1 for exactly one cycle, sd_addr/sd_din from the hold register, hold register freed, state goes to WR.
- REQ-025 IDLE, hold register empty, dl_active=0 and any ch_req bit set: grant one channel round-robin, searching from the channel after the last granted one.
  - Next cycle: sd_rd=1 for exactly one cycle, sd_addr={ch_addr[n],1'b0} zero-extended to ADDR_W, state goes to RD.
  - The round-robin pointer SHALL update only on a grant; the reset pointer makes channel 0 the first searched.
- REQ-026 WR: sd_ready SHALL return the FSM to IDLE.
- REQ-027 RD: sd_ready SHALL register sd_dout into ch_data and move to ACK.
  - ACK lasts exactly one cycle with ch_ack[grant]=1, then returns to IDLE.
  - Latency from sd_ready to ch_ack is 1 cycle.
- REQ-028 The arbiter SHALL handle mid-transaction changes as follows:
  - ch_req dropping during RD or ACK SHALL NOT cancel the transaction; ack is still pulsed.
  - dl_active rising during RD SHALL let the read complete.
  - sd_ready received in IDLE or ACK SHALL be ignored.

Reset
- REQ-030 While reset_n=0, every output SHALL be 0. This covers ch_ack, ch_data, sd_addr, sd_we, sd_rd, sd_din, busy, dl_ovf and err.
- REQ-031 While reset_n=0, the FSM SHALL be in IDLE, the hold register empty and the round-robin pointer at 3. Reset asserted mid-transaction aborts the transaction with no ack issued.

Configuration
- REQ-029 With SAMPLE_ARB_TIMEOUT_EN defined, a counter SHALL run in WR and RD.
  - It clears on state entry.
  - On reaching TIMEOUT cycles without sd_ready it sets err. WR then returns to IDLE; RD then goes to ACK with ch_data=16'h0000.
- REQ-032 Without SAMPLE_ARB_TIMEOUT_EN, no counter SHALL be built, WR and RD SHALL wait for sd_ready indefinitely, and err SHALL be tied to 0.

Verification
- REQ-033 Reset, then ch_req=4'b0001, ch_addr[0]=20'h00123 -> sd_rd pulse with sd_addr=25'h0000246. sd_ready with sd_dout=16'hBEEF three cycles later -> ch_ack=4'b0001 and ch_data=16'hBEEF one cycle after sd_ready.
- REQ-034 ch_req=4'b1111 held with sd_ready returned for every read -> grant order 0,1,2,3,0.
- REQ-035 dl_wr (addr 25'h10, data 8'h5A) in the same cycle as ch_req=4'b0010, FSM in IDLE -> sd_we first with sd_addr=25'h10 and sd_din=8'h5A. The read is not issued while dl_active=1; it is issued after dl_active falls.
- REQ-036 Two dl_wr pulses in successive cycles while in RD -> first write held, second dropped, dl_ovf=1 and sticky until reset.
- REQ-037 With SAMPLE_ARB_TIMEOUT_EN and TIMEOUT=64, sd_ready withheld after sd_rd -> ch_ack with ch_data=16'h0000 after 64 cycles, err=1.
- REQ-038 reset_n pulsed low during RD -> all outputs 0 immediately. No ch_ack after release; the next grant goes to channel 0.

Source files
------------

// File: rtl/wave_sdram_arbiter.sv
// rtl/wave_sdram_arbiter.sv - SDRAM arbiter: ROM download writes plus 4 round-robin wave read channels.
// Optional SDRAM watchdog enabled by defining SAMPLE_ARB_TIMEOUT_EN.
module wave_sdram_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic [3:0]        ch_req,
    input  logic [79:0]       ch_addr,
    output logic [3:0]        ch_ack,
    output logic [15:0]       ch_data,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_we,
    output logic              sd_rd,
    output logic [7:0]        sd_din,
    input  logic [15:0]       sd_dout,
    input  logic              sd_ready,
    output logic              busy,
    output logic              dl_ovf,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic              hold_vld_q, hold_vld_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic [1:0]        rr_q, rr_d;
    logic [3:0]        ch_ack_q, ch_ack_d;
    logic [15:0]       ch_data_q, ch_data_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic              sd_we_q, sd_we_d;
    logic              sd_rd_q, sd_rd_d;
    logic [7:0]        sd_din_q, sd_din_d;
    logic              dl_ovf_q, dl_ovf_d;

    logic              hold_take;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [19:0]       gnt_addr;
    logic              to_hit;

    // Round-robin search: walk from furthest to nearest so the channel right after rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        cand    = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = rr_q + 2'(i);
            if (ch_req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    gnt_addr = ch_addr[19:0];
            2'd1:    gnt_addr = ch_addr[39:20];
            2'd2:    gnt_addr = ch_addr[59:40];
            default: gnt_addr = ch_addr[79:60];
        endcase
    end

    assign hold_take = (state_q == ST_IDLE) && hold_vld_q;

    // A slot being drained this cycle may be refilled by a coincident dl_wr.
    always_comb begin
        hold_vld_d  = hold_vld_q & ~hold_take;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        dl_ovf_d    = dl_ovf_q;
        if (dl_wr) begin
            if (hold_vld_q && !hold_take) begin
                dl_ovf_d = 1'b1;
            end else begin
                hold_vld_d  = 1'b1;
                hold_addr_d = dl_addr;
                hold_data_d = dl_data;
            end
        end
    end

`ifdef SAMPLE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt_q;
    logic             err_q;

    assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_d != state_q || state_q == ST_IDLE || state_q == ST_ACK) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if ((state_q == ST_WR || state_q == ST_RD) && !sd_ready && to_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        ch_ack_d  = 4'b0000;
        ch_data_d = ch_data_q;
        sd_addr_d = sd_addr_q;
        sd_we_d   = 1'b0;
        sd_rd_d   = 1'b0;
        sd_din_d  = sd_din_q;
        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    sd_we_d   = 1'b1;
                    sd_addr_d = hold_addr_q;
                    sd_din_d  = hold_data_q;
                    state_d   = ST_WR;
                end else if (!dl_active && gnt_vld) begin
                    sd_rd_d   = 1'b1;
                    sd_addr_d = ADDR_W'({gnt_addr, 1'b0});
                    rr_d      = gnt_idx;
                    state_d   = ST_RD;
                end
            end
            ST_WR: begin
                if (sd_ready || to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // rr_q holds the channel granted for this read.
                if (sd_ready) begin
                    ch_data_d = sd_dout;
                    ch_ack_d  = 4'b0001 << rr_q;
                    state_d   = ST_ACK;
                end else if (to_hit) begin
                    ch_data_d = 16'h0000;
                    ch_ack_d  = 4'b0001 << rr_q;
                    state_d   = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            rr_q        <= 2'd3;
            ch_ack_q    <= '0;
            ch_data_q   <= '0;
            sd_addr_q   <= '0;
            sd_we_q     <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_din_q    <= '0;
            dl_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            rr_q        <= rr_d;
            ch_ack_q    <= ch_ack_d;
            ch_data_q   <= ch_data_d;
            sd_addr_q   <= sd_addr_d;
            sd_we_q     <= sd_we_d;
            sd_rd_q     <= sd_rd_d;
            sd_din_q    <= sd_din_d;
            dl_ovf_q    <= dl_ovf_d;
        end
    end

    assign ch_ack  = ch_ack_q;
    assign ch_data = ch_data_q;
    assign sd_addr = sd_addr_q;
    assign sd_we   = sd_we_q;
    assign sd_rd   = sd_rd_q;
    assign sd_din  = sd_din_q;
    assign busy    = (state_q != ST_IDLE);
    assign dl_ovf  = dl_ovf_q;

endmodule
